// File: rtl/issue_scoreboard_if.sv
// ============================================================================
// issue_scoreboard_if : decode <-> scoreboard bundle/interlock signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface issue_scoreboard_if;
    logic [63:0] inst;
    logic        inst_valid;
    logic        flush;
    logic        interlock;
    logic        issue;
    logic        fdiv_busy;
    logic [31:0] pending;

    modport master (
        output inst, inst_valid, flush,
        input  interlock, issue, fdiv_busy, pending
    );

    modport slave (
        input  inst, inst_valid, flush,
        output interlock, issue, fdiv_busy, pending
    );
endinterface

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// ============================================================================
// issue_scoreboard : per-GPR countdown scoreboard and dual-slot issue interlock
// Optional macro STALL_PERF_CNT_EN adds stall_cycles / issue_count outputs.
// Rev 1.0
// ============================================================================
`default_nettype none

module issue_scoreboard #(
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 3,
    parameter int FPU_LAT  = 4,
    parameter int FDIV_LAT = 12,
    parameter int CNT_W    = 4
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    issue_scoreboard_if.slave sb
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       issue_count
`endif
);

    localparam logic [5:0] c_OP_ADD   = 6'd1,  c_OP_SUB   = 6'd2,  c_OP_ADDI  = 6'd3;
    localparam logic [5:0] c_OP_SUBI  = 6'd4,  c_OP_SRAWI = 6'd5,  c_OP_SLAWI = 6'd6;
    localparam logic [5:0] c_OP_LI    = 6'd7,  c_OP_LIW   = 6'd8,  c_OP_LOAD  = 6'd9;
    localparam logic [5:0] c_OP_STORE = 6'd10, c_OP_JUMP  = 6'd11, c_OP_BLR   = 6'd12;
    localparam logic [5:0] c_OP_BL    = 6'd13, c_OP_BLRR  = 6'd14, c_OP_BEQ   = 6'd15;
    localparam logic [5:0] c_OP_BLE   = 6'd16, c_OP_BLT   = 6'd17, c_OP_CMPD  = 6'd18;
    localparam logic [5:0] c_OP_CMPDI = 6'd19, c_OP_CMPF  = 6'd20, c_OP_FADD  = 6'd21;
    localparam logic [5:0] c_OP_FSUB  = 6'd22, c_OP_FMUL  = 6'd23, c_OP_FDIV  = 6'd24;
    localparam logic [5:0] c_OP_FSQRT = 6'd25, c_OP_FTOI  = 6'd26, c_OP_ITOF  = 6'd27;
    localparam logic [5:0] c_OP_INLL  = 6'd28, c_OP_INLH  = 6'd29, c_OP_INUL  = 6'd30;
    localparam logic [5:0] c_OP_INUH  = 6'd31, c_OP_OUTLL = 6'd32;

    localparam logic [CNT_W-1:0] c_ALU_LAT  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] c_LOAD_LAT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] c_FPU_LAT  = CNT_W'(FPU_LAT);
    localparam logic [CNT_W-1:0] c_FDIV_LAT = CNT_W'(FDIV_LAT);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    if (ALU_LAT < 1 || LOAD_LAT < 1 || FPU_LAT < 1 || FDIV_LAT < 1 ||
        ALU_LAT > (2**CNT_W)-1 || LOAD_LAT > (2**CNT_W)-1 ||
        FPU_LAT > (2**CNT_W)-1 || FDIV_LAT > (2**CNT_W)-1) begin : g_lat_check
        $error("issue_scoreboard: every latency must be in 1 .. 2**CNT_W-1");
    end

    typedef struct packed {
        logic             ra_v;
        logic [4:0]       ra;
        logic             rb_v;
        logic [4:0]       rb;
        logic             rs_v;
        logic [4:0]       rs;
        logic             dst_v;
        logic [4:0]       dst;
        logic [CNT_W-1:0] lat;
        logic             fdiv;
    } slot_t;

    // Argument is word[31:11] of a slot: op, rt, ra, rb.
    function automatic slot_t f_decode(input logic [20:0] f);
        slot_t s;
        s     = '0;
        s.ra  = f[9:5];
        s.rb  = f[4:0];
        s.rs  = f[14:10];
        s.dst = f[14:10];
        case (f[20:15])
            c_OP_ADD, c_OP_SUB: begin
                s.ra_v = 1'b1; s.rb_v = 1'b1; s.dst_v = 1'b1; s.lat = c_ALU_LAT;
            end
            c_OP_ADDI, c_OP_SUBI, c_OP_SRAWI, c_OP_SLAWI: begin
                s.ra_v = 1'b1; s.dst_v = 1'b1; s.lat = c_ALU_LAT;
            end
            c_OP_LI, c_OP_LIW, c_OP_INLL, c_OP_INLH, c_OP_INUL, c_OP_INUH: begin
                s.dst_v = 1'b1; s.lat = c_ALU_LAT;
            end
            c_OP_LOAD: begin
                s.ra_v = 1'b1; s.dst_v = 1'b1; s.lat = c_LOAD_LAT;
            end
            c_OP_STORE: begin
                s.ra_v = 1'b1; s.rs_v = 1'b1;
            end
            c_OP_OUTLL: s.rs_v = 1'b1;
            c_OP_BL: begin
                s.dst_v = 1'b1; s.dst = 5'd31; s.lat = c_ALU_LAT;
            end
            c_OP_BLRR: begin
                s.rs_v = 1'b1; s.dst_v = 1'b1; s.dst = 5'd31; s.lat = c_ALU_LAT;
            end
            c_OP_BLR: begin
                s.rs_v = 1'b1; s.rs = 5'd31;
            end
            c_OP_CMPD, c_OP_CMPF: begin
                s.ra_v = 1'b1; s.rb_v = 1'b1;
            end
            c_OP_CMPDI: s.ra_v = 1'b1;
            c_OP_FADD, c_OP_FSUB, c_OP_FMUL: begin
                s.ra_v = 1'b1; s.rb_v = 1'b1; s.dst_v = 1'b1; s.lat = c_FPU_LAT;
            end
            c_OP_FDIV: begin
                s.ra_v = 1'b1; s.rb_v = 1'b1; s.dst_v = 1'b1; s.lat = c_FDIV_LAT; s.fdiv = 1'b1;
            end
            c_OP_FSQRT, c_OP_FTOI, c_OP_ITOF: begin
                s.ra_v = 1'b1; s.dst_v = 1'b1; s.lat = c_FPU_LAT;
            end
            default: ;
        endcase
        return s;
    endfunction

    logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]       fdiv_q, fdiv_d;
    slot_t                  w_slot [2];
    logic [1:0]             w_slot_en;
    logic                   w_lo_off, w_go, w_haz, w_interlock, w_issue, w_fdiv_iss;
    logic [31:0]            w_pend;
    logic                   w_unused_bits;

    assign w_unused_bits = ^{sb.inst[42:32], sb.inst[10:0]};

    assign w_slot[0] = f_decode(sb.inst[63:43]);
    assign w_slot[1] = f_decode(sb.inst[31:11]);
    // Upper-slot branches and Liw use the lower word as immediate/Nop.
    assign w_lo_off  = sb.inst[63:58] inside {c_OP_LIW, c_OP_JUMP, c_OP_BLR, c_OP_BL,
                                              c_OP_BLRR, c_OP_BEQ, c_OP_BLE, c_OP_BLT};
    assign w_slot_en = {~w_lo_off, 1'b1};

    always_comb begin
        w_haz = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (w_slot_en[s]) begin
                if (w_slot[s].ra_v && cnt_q[w_slot[s].ra] != '0) w_haz = 1'b1;
                if (w_slot[s].rb_v && cnt_q[w_slot[s].rb] != '0) w_haz = 1'b1;
                if (w_slot[s].rs_v && cnt_q[w_slot[s].rs] != '0) w_haz = 1'b1;
                if (w_slot[s].dst_v && cnt_q[w_slot[s].dst] > w_slot[s].lat) w_haz = 1'b1;
                if (w_slot[s].fdiv && fdiv_q != '0) w_haz = 1'b1;
            end
        end
    end

    assign w_go        = rstn & sb.inst_valid & ~sb.flush;
    assign w_interlock = w_go & w_haz;
    assign w_issue     = w_go & ~w_haz;
    assign w_fdiv_iss  = w_issue & (w_slot[0].fdiv | (w_slot_en[1] & w_slot[1].fdiv));

    // Counter holds cycles remaining minus one, so a read is allowed when it hits zero.
    always_comb begin
        logic             ld;
        logic [CNT_W-1:0] ldv;
        ld  = 1'b0;
        ldv = '0;
        for (int i = 0; i < 32; i++) begin
            ld       = 1'b0;
            ldv      = '0;
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - c_ONE : '0;
            for (int s = 0; s < 2; s++) begin
                if (w_issue && w_slot_en[s] && w_slot[s].dst_v && w_slot[s].dst == 5'(i)) begin
                    ld = 1'b1;
                    if (w_slot[s].lat - c_ONE > ldv) ldv = w_slot[s].lat - c_ONE;
                end
            end
            if (ld) cnt_d[i] = ldv;
        end
        fdiv_d = w_fdiv_iss ? c_FDIV_LAT - c_ONE : ((fdiv_q != '0) ? fdiv_q - c_ONE : '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q  <= '0;
            fdiv_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fdiv_q <= fdiv_d;
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_pend
        assign w_pend[i] = rstn & (cnt_q[i] != '0);
    end

    assign sb.interlock = w_interlock;
    assign sb.issue     = w_issue;
    assign sb.fdiv_busy = rstn & (fdiv_q != '0);
    assign sb.pending   = w_pend;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_q, issue_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q     <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (w_interlock) stall_q     <= stall_q + 32'd1;
            if (w_issue)     issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign issue_count  = issue_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// ============================================================================
// tb_issue_scoreboard : directed scenarios plus random bundles vs. ready-time model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_issue_scoreboard;
    localparam int ALU_LAT = 1, LOAD_LAT = 3, FPU_LAT = 4, FDIV_LAT = 12;

    localparam logic [5:0] NOP = 0, ADD = 1, SUB = 2, ADDI = 3, SUBI = 4, SRAWI = 5, SLAWI = 6;
    localparam logic [5:0] LI = 7, LIW = 8, LOAD = 9, STORE = 10, JUMP = 11, BLR = 12, BL = 13;
    localparam logic [5:0] BLRR = 14, BEQ = 15, BLE = 16, BLT = 17, CMPD = 18, CMPDI = 19;
    localparam logic [5:0] CMPF = 20, FADD = 21, FSUB = 22, FMUL = 23, FDIV = 24, FSQRT = 25;
    localparam logic [5:0] FTOI = 26, ITOF = 27, INLL = 28, INLH = 29, INUL = 30, INUH = 31;
    localparam logic [5:0] OUTLL = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    issue_scoreboard_if sbif ();
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles, issue_count;
`endif

    issue_scoreboard dut (
        .clk  (clk),
        .rstn (rstn),
        .sb   (sbif)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .issue_count  (issue_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;
    int unsigned ready [32];     // first cycle at which register may be read
    int unsigned fdiv_free = 0;  // first cycle at which the divider accepts
    logic [31:0] m_stall = 0, m_issued = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input int rt, input int ra, input int rb);
        return {op, 5'(rt), 5'(ra), 5'(rb), 11'd0};
    endfunction

    function automatic bit lower_off(input logic [63:0] b);
        return b[63:58] inside {LIW, JUMP, BLR, BL, BLRR, BEQ, BLE, BLT};
    endfunction

    function automatic bit busy(input int r);
        return ready[r] > cyc;
    endfunction

    function automatic int dst_reg(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op inside {BL, BLRR}) return 31;
        if (op inside {ADD, SUB, ADDI, SUBI, SRAWI, SLAWI, LI, LIW, INLL, INLH, INUL, INUH,
                       LOAD, FADD, FSUB, FMUL, FDIV, FSQRT, FTOI, ITOF}) return int'(w[25:21]);
        return -1;
    endfunction

    function automatic int dst_lat(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == LOAD) return LOAD_LAT;
        if (op == FDIV) return FDIV_LAT;
        if (op inside {FADD, FSUB, FMUL, FSQRT, FTOI, ITOF}) return FPU_LAT;
        return ALU_LAT;
    endfunction

    function automatic bit slot_hazard(input logic [31:0] w);
        logic [5:0] op;
        bit         h;
        int         d;
        op = w[31:26];
        h  = 1'b0;
        if (op inside {ADDI, SUBI, ADD, SUB, SRAWI, SLAWI, FADD, FSUB, FMUL, FDIV, FSQRT,
                       FTOI, ITOF, LOAD, STORE, CMPD, CMPDI, CMPF}) h |= busy(int'(w[20:16]));
        if (op inside {ADD, SUB, FADD, FSUB, FMUL, FDIV, CMPD, CMPF}) h |= busy(int'(w[15:11]));
        if (op inside {STORE, BLRR, OUTLL}) h |= busy(int'(w[25:21]));
        if (op == BLR) h |= busy(31);
        d = dst_reg(w);
        if (d >= 0 && ready[d] > cyc + dst_lat(w)) h = 1'b1;
        if (op == FDIV && fdiv_free > cyc) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_hazard();
        return slot_hazard(sbif.inst[63:32]) || (!lower_off(sbif.inst) && slot_hazard(sbif.inst[31:0]));
    endfunction

    function automatic bit m_active();
        return rstn && sbif.inst_valid && !sbif.flush;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        for (int r = 0; r < 32; r++) p[r] = rstn && busy(r);
        return p;
    endfunction

    function automatic void commit_bundle();
        int          du, dl;
        int unsigned ru, rl;
        bit          lo_en;
        lo_en = !lower_off(sbif.inst);
        du = dst_reg(sbif.inst[63:32]);
        dl = lo_en ? dst_reg(sbif.inst[31:0]) : -1;
        ru = cyc + dst_lat(sbif.inst[63:32]);
        rl = cyc + dst_lat(sbif.inst[31:0]);
        if (du >= 0 && du == dl) begin
            ready[du] = (ru > rl) ? ru : rl;
        end else begin
            if (du >= 0) ready[du] = ru;
            if (dl >= 0) ready[dl] = rl;
        end
        if (sbif.inst[63:58] == FDIV || (lo_en && sbif.inst[31:26] == FDIV))
            fdiv_free = cyc + FDIV_LAT;
    endfunction

    // Reference model advances on the same edge the DUT registers do.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) ready[r] = 0;
            fdiv_free = 0;
            m_stall   = 0;
            m_issued  = 0;
        end else if (m_active()) begin
            if (m_hazard()) begin
                m_stall = m_stall + 1;
            end else begin
                m_issued = m_issued + 1;
                commit_bundle();
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        chk("interlock", 32'(sbif.interlock), 32'(m_active() && m_hazard()));
        chk("issue", 32'(sbif.issue), 32'(m_active() && !m_hazard()));
        chk("fdiv_busy", 32'(sbif.fdiv_busy), 32'(rstn && fdiv_free > cyc));
        chk("pending", sbif.pending, m_pending());
`ifdef STALL_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("issue_count", issue_count, m_issued);
`endif
    end

    task automatic drive(input logic [31:0] up, input logic [31:0] lo, input logic v, input logic fl);
        sbif.inst       = {up, lo};
        sbif.inst_valid = v;
        sbif.flush      = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (n) step();
    endtask

    function automatic logic [31:0] rnd_word();
        int r;
        r = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
        return mk(6'($urandom_range(0, 32)), r, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endfunction

    initial begin
        logic [31:0] up, lo;
        drive(mk(LOAD, 5, 1, 0), 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_interlock", 32'(sbif.interlock), 32'd0);
        chk("rst_issue", 32'(sbif.issue), 32'd0);
        chk("rst_pending", sbif.pending, 32'd0);
        step();
        idle(1);
        rstn = 1'b1;
        idle(2);

        // Load -> dependent Add
        drive(mk(LOAD, 5, 1, 0), 32'd0, 1'b1, 1'b0);
        @(negedge clk); chk("s1_load_issue", 32'(sbif.issue), 32'd1);
        step();
        for (int k = 1; k <= 2; k++) begin
            drive(mk(ADD, 6, 5, 7), 32'd0, 1'b1, 1'b0);
            @(negedge clk); chk("s1_interlock", 32'(sbif.interlock), 32'd1);
            step();
        end
        @(negedge clk); chk("s1_issue_t3", 32'(sbif.issue), 32'd1);
        step();

        // ALU result readable next cycle
        drive(mk(ADDI, 3, 1, 0), 32'd0, 1'b1, 1'b0);
        step();
        drive(mk(SUB, 4, 3, 3), 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("s2_interlock", 32'(sbif.interlock), 32'd0);
        chk("s2_pending3", 32'(sbif.pending[3]), 32'd0);
        step();

        // Divider occupancy
        drive(mk(FDIV, 8, 1, 2), 32'd0, 1'b1, 1'b0);
        @(negedge clk); chk("s3_fdiv_issue", 32'(sbif.issue), 32'd1);
        step();
        for (int k = 1; k <= 11; k++) begin
            drive(mk(FDIV, 9, 11, 12), 32'd0, 1'b1, 1'b0);
            @(negedge clk);
            chk("s3_interlock", 32'(sbif.interlock), 32'd1);
            chk("s3_fdiv_busy", 32'(sbif.fdiv_busy), 32'd1);
            step();
        end
        @(negedge clk);
        chk("s3_issue_t12", 32'(sbif.issue), 32'd1);
        chk("s3_fdiv_free", 32'(sbif.fdiv_busy), 32'd0);
        step();
        idle(14);

        // Flushed load leaves no tracking
        drive(mk(LOAD, 5, 1, 0), 32'd0, 1'b1, 1'b1);
        @(negedge clk); chk("s4_flush_issue", 32'(sbif.issue), 32'd0);
        step();
        drive(mk(ADD, 6, 5, 7), 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("s4_pending5", 32'(sbif.pending[5]), 32'd0);
        chk("s4_issue", 32'(sbif.issue), 32'd1);
        step();

        // WAW ordering
        drive(mk(FMUL, 2, 1, 3), 32'd0, 1'b1, 1'b0);
        step();
        for (int k = 1; k <= 2; k++) begin
            drive(mk(ADDI, 2, 1, 0), 32'd0, 1'b1, 1'b0);
            @(negedge clk); chk("s5_interlock", 32'(sbif.interlock), 32'd1);
            step();
        end
        @(negedge clk); chk("s5_issue_t3", 32'(sbif.issue), 32'd1);
        step();
        idle(14);

        // Reset mid-flight
        drive(mk(FDIV, 10, 1, 3), 32'd0, 1'b1, 1'b0);
        step();
        idle(0);
        @(negedge clk);
        chk("s6_busy_before", 32'(sbif.fdiv_busy), 32'd1);
        chk("s6_pend10_before", 32'(sbif.pending[10]), 32'd1);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        drive(mk(FDIV, 13, 1, 3), 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("s6_pending", sbif.pending, 32'd0);
        chk("s6_fdiv_busy", 32'(sbif.fdiv_busy), 32'd0);
        chk("s6_issue", 32'(sbif.issue), 32'd1);
        step();

        // Random bundles
        up = 32'd0;
        lo = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                up = rnd_word();
                lo = rnd_word();
                if (up[31:26] == FDIV && lo[31:26] == FDIV) lo = 32'd0;
            end
            rstn = ($urandom_range(0, 199) != 0);
            drive(up, lo, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
            step();
        end
        rstn = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
